// File: rtl/spi_master_arb.sv
// SPI mode-0 master shared by two byte-stream requesters, one owner per chip-select window.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module spi_master_arb #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_last_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_last_i,
    output logic       req1_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_id_o,
    output logic       busy_o,
    output logic       spi_clk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_o,
    input  logic       spi_miso_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_HOLD, S_GAP
    } state_t;

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic          r_phase;
    logic          r_owner;
    logic          r_last;
    logic [6:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_cs;
    logic          r_sclk;
    logic          r_mosi;
    logic          r_ready;
    logic          r_busy;
    logic          r_rx_valid;
    logic [7:0]    r_rx_data;
    logic          r_rx_id;

    logic          w_any;
    logic          w_grant;
    logic          w_own_valid;
    logic [7:0]    w_own_data;
    logic          w_own_last;
    logic          w_div_done;
    logic          w_gap_done;

    assign w_any       = req0_valid_i | req1_valid_i;
    assign w_own_valid = r_owner ? req1_valid_i : req0_valid_i;
    assign w_own_data  = r_owner ? req1_data_i  : req0_data_i;
    assign w_own_last  = r_owner ? req1_last_i  : req0_last_i;
    assign w_div_done  = (r_cnt == CW'(CLK_DIV - 1));
    assign w_gap_done  = (r_cnt == CW'(CS_GAP - 1));

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic r_rr_ptr;

    always_comb begin
        w_grant = req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            w_grant = r_rr_ptr;
        end
    end

    // Pointer favours whichever requester was not granted most recently.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rr_ptr <= 1'b0;
        end else if (r_state == S_IDLE && w_any) begin
            r_rr_ptr <= ~w_grant;
        end
    end
`else
    assign w_grant = ~req0_valid_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_phase    <= 1'b0;
            r_owner    <= 1'b0;
            r_last     <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_id    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_grant;
                        r_state <= S_SETUP;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_SETUP: begin
                    if (w_div_done) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_LOAD: begin
                    if (w_own_valid) begin
                        r_tx    <= w_own_data[6:0];
                        r_mosi  <= w_own_data[7];
                        r_last  <= w_own_last;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_phase <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!w_div_done) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            // MISO captured on the same edge that raises SCLK.
                            r_sclk  <= 1'b1;
                            r_phase <= 1'b1;
                            r_rx    <= {r_rx[6:0], spi_miso_i};
                        end else begin
                            r_sclk  <= 1'b0;
                            r_phase <= 1'b0;
                            if (r_bit == 3'd7) begin
                                r_rx_valid <= 1'b1;
                                r_rx_data  <= r_rx;
                                r_rx_id    <= r_owner;
                                r_mosi     <= 1'b0;
                                if (r_last) begin
                                    r_state <= S_HOLD;
                                end else begin
                                    r_state <= S_LOAD;
                                    r_ready <= 1'b1;
                                end
                            end else begin
                                r_bit  <= r_bit + 3'd1;
                                r_mosi <= r_tx[6];
                                r_tx   <= {r_tx[5:0], 1'b0};
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_div_done) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_done) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready_o = r_ready & ~r_owner;
    assign req1_ready_o = r_ready &  r_owner;
    assign rx_data_o    = r_rx_data;
    assign rx_valid_o   = r_rx_valid;
    assign rx_id_o      = r_rx_id;
    assign busy_o       = r_busy;
    assign spi_clk_o    = r_sclk;
    assign spi_mosi_o   = r_mosi;
    assign spi_cs_o     = r_cs;

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: vector table of single-byte transactions plus
// hand-written sequences for multi-byte, contention, mid-byte reset and arbitration.
module tb_spi_master_arb;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;
    localparam int LIM     = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1, l0, l1;
    logic [7:0] d0, d1;
    logic       rdy0, rdy1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_id, busy;
    logic       spi_clk, spi_mosi, spi_cs, spi_miso;

    always #5 clk = ~clk;

    spi_master_arb #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(v0), .req0_data_i(d0), .req0_last_i(l0), .req0_ready_o(rdy0),
        .req1_valid_i(v1), .req1_data_i(d1), .req1_last_i(l1), .req1_ready_o(rdy1),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_id_o(rx_id), .busy_o(busy),
        .spi_clk_o(spi_clk), .spi_mosi_o(spi_mosi), .spi_cs_o(spi_cs), .spi_miso_i(spi_miso)
    );

    // Slave model: presents miso_byte MSB first, advancing after each SCLK rise.
    int         rise_cnt  = 0;
    int         rise_base = 0;
    logic [7:0] miso_byte = 8'h00;
    logic [7:0] mosi_cap  = 8'h00;
    logic [2:0] miso_idx;
    assign miso_idx = 3'd7 - 3'(rise_cnt - rise_base);
    assign spi_miso = miso_byte[miso_idx];

    always @(posedge spi_clk) begin
        rise_cnt <= rise_cnt + 1;
        mosi_cap <= {mosi_cap[6:0], spi_mosi};
    end

    logic [7:0] rx_log_d [64];
    logic       rx_log_id[64];
    int         rx_n      = 0;
    logic       prev_cs   = 1'b1;
    int         run       = 0;
    int         last_low  = 0;
    int         last_high = 0;
    int         low_runs  = 0;
    int         mon_err   = 0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_log_d[rx_n]  <= rx_data;
            rx_log_id[rx_n] <= rx_id;
            rx_n            <= rx_n + 1;
        end
        if (spi_cs === prev_cs) begin
            run <= run + 1;
        end else begin
            if (prev_cs) last_high <= run;
            else begin
                last_low <= run;
                low_runs <= low_runs + 1;
            end
            run <= 1;
        end
        prev_cs <= spi_cs;
        if (spi_cs === 1'b1 && spi_mosi === 1'b1) mon_err <= mon_err + 1;
        if (busy === 1'b0 && (spi_cs === 1'b0 || spi_clk === 1'b1)) mon_err <= mon_err + 1;
        if (rdy0 === 1'b1 && rdy1 === 1'b1) mon_err <= mon_err + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, LIM);
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [7:0] d, input logic last);
        int t;
        if (id) begin v1 = 1'b1; d1 = d; l1 = last; end
        else    begin v0 = 1'b1; d0 = d; l0 = last; end
        t = 0;
        while (!(id ? rdy1 : rdy0) && t < LIM) begin step; t++; end
        if (t >= LIM) timeout("send_ready");
        step;
        if (id) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic wait_idle;
        int t;
        t = 0;
        step;
        while (busy && t < LIM) begin step; t++; end
        if (t >= LIM) timeout("wait_idle");
        step;
    endtask

    typedef struct {
        logic       id;
        logic [7:0] tx;
        logic [7:0] miso;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
        int         exp_cs_low;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0, lr, t, rdy_cnt, rdy1_seen;
        int exp_g[3];

        // SETUP(2) + LOAD(1) + SHIFT(32) + HOLD(2) = 37 cycles of cs low.
        vecs[0] = '{1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 37};
        vecs[1] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 37};
        vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, 37};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 37};
        vecs[4] = '{1'b0, 8'h80, 8'h01, 8'h80, 8'h01, 37};

        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        step; step;
        chk("rst_cs", spi_cs, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_ready", {rdy1, rdy0}, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_id", rx_id, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step;

        for (int i = 0; i < 5; i++) begin
            miso_byte = vecs[i].miso;
            rise_base = rise_cnt;
            r0 = rx_n;
            send(vecs[i].id, vecs[i].tx, 1'b1);
            wait_idle;
            chk($sformatf("v%0d_mosi", i), mosi_cap, vecs[i].exp_mosi);
            chk($sformatf("v%0d_sclk_rises", i), rise_cnt - rise_base, 8);
            chk($sformatf("v%0d_rx_count", i), rx_n - r0, 1);
            chk($sformatf("v%0d_rx_data", i), rx_log_d[r0], vecs[i].exp_rx);
            chk($sformatf("v%0d_rx_id", i), rx_log_id[r0], vecs[i].id);
            chk($sformatf("v%0d_cs_low", i), last_low, vecs[i].exp_cs_low);
            $display("vec %0d: id=%0d tx=%02h rx=%02h cs_low=%0d", i, vecs[i].id, vecs[i].tx,
                     rx_log_d[r0], last_low);
        end

        // Two-byte transaction from requester 1 with a stalled LOAD between bytes.
        miso_byte = 8'h96;
        rise_base = rise_cnt;
        r0 = rx_n;
        lr = low_runs;
        send(1'b1, 8'h01, 1'b0);
        t = 0;
        while (!rdy1 && t < LIM) begin step; t++; end
        if (t >= LIM) timeout("multi_load_wait");
        rdy_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (rdy1) rdy_cnt++;
            step;
        end
        send(1'b1, 8'h02, 1'b1);
        wait_idle;
        chk("multi_load_hold", rdy_cnt, 5);
        chk("multi_rx_count", rx_n - r0, 2);
        chk("multi_rx0_data", rx_log_d[r0], 8'h96);
        chk("multi_rx1_data", rx_log_d[r0 + 1], 8'h96);
        chk("multi_rx_ids", {rx_log_id[r0], rx_log_id[r0 + 1]}, 2'b11);
        chk("multi_sclk_rises", rise_cnt - rise_base, 16);
        chk("multi_cs_windows", low_runs - lr, 1);
        chk("multi_cs_low", last_low, 75);
        chk("multi_last_mosi", mosi_cap, 8'h02);
        $display("multi: bytes=%0d rises=%0d cs_low=%0d", rx_n - r0, rise_cnt - rise_base, last_low);

        // Requester 1 waits while requester 0 owns the bus.
        miso_byte = 8'h5A;
        rise_base = rise_cnt;
        r0 = rx_n;
        v0 = 1'b1; d0 = 8'h33; l0 = 1'b1;
        step;
        v1 = 1'b1; d1 = 8'h44; l1 = 1'b1;
        t = 0;
        while (!rdy0 && t < LIM) begin step; t++; end
        if (t >= LIM) timeout("contend_ready0");
        step;
        v0 = 1'b0;
        rdy1_seen = 0;
        t = 0;
        while (busy && t < LIM) begin
            if (rdy1) rdy1_seen++;
            step;
            t++;
        end
        if (t >= LIM) timeout("contend_busy");
        chk("contend_ready1_blocked", rdy1_seen, 0);
        t = 0;
        while (!rdy1 && t < LIM) begin step; t++; end
        if (t >= LIM) timeout("contend_ready1");
        step;
        v1 = 1'b0;
        wait_idle;
        chk("contend_rx_count", rx_n - r0, 2);
        chk("contend_first_id", rx_log_id[r0], 0);
        chk("contend_second_id", rx_log_id[r0 + 1], 1);
        chk("contend_rx_data", rx_log_d[r0 + 1], 8'h5A);
        chk("contend_cs_gap", last_high, CS_GAP + 1);
        $display("contend: ids=%0d,%0d gap=%0d", rx_log_id[r0], rx_log_id[r0 + 1], last_high);

        // Reset after the 4th SCLK rise of a byte.
        miso_byte = 8'hA5;
        rise_base = rise_cnt;
        r0 = rx_n;
        send(1'b0, 8'hA5, 1'b1);
        t = 0;
        while (rise_cnt - rise_base < 4 && t < LIM) begin step; t++; end
        if (t >= LIM) timeout("reset_wait_rise");
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        chk("abort_cs", spi_cs, 1);
        chk("abort_sclk", spi_clk, 0);
        chk("abort_busy", busy, 0);
        for (int k = 0; k < 20; k++) step;
        chk("abort_no_rx", rx_n - r0, 0);
        chk("abort_rises", rise_cnt - rise_base, 4);
        $display("abort: rises=%0d rx=%0d", rise_cnt - rise_base, rx_n - r0);

        miso_byte = 8'h3C;
        rise_base = rise_cnt;
        r0 = rx_n;
        send(1'b0, 8'hA5, 1'b1);
        wait_idle;
        chk("after_abort_rx_data", rx_log_d[r0], 8'h3C);
        chk("after_abort_rx_id", rx_log_id[r0], 0);
        chk("after_abort_mosi", mosi_cap, 8'hA5);
        chk("after_abort_rises", rise_cnt - rise_base, 8);
        $display("after_abort: rx=%02h cs_low=%0d", rx_log_d[r0], last_low);

        // Three back-to-back ties from a fresh reset.
`ifdef SPI_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0};
`else
        exp_g = '{0, 0, 0};
`endif
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        step;
        miso_byte = 8'h00;
        r0 = rx_n;
        v0 = 1'b1; d0 = 8'h11; l0 = 1'b1;
        v1 = 1'b1; d1 = 8'h22; l1 = 1'b1;
        t = 0;
        while (rx_n - r0 < 3 && t < 3 * LIM) begin step; t++; end
        if (t >= 3 * LIM) timeout("tie_wait_rx");
        v0 = 1'b0;
        v1 = 1'b0;
        wait_idle;
        chk("tie_rx_count", rx_n - r0, 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("tie_grant%0d", k), rx_log_id[r0 + k], exp_g[k]);
            $display("tie %0d: id=%0d", k, rx_log_id[r0 + k]);
        end

        chk("monitor_invariants", mon_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
